fp_sqrt_iter: RTL and testbench
===============================

Name: fp_sqrt_iter

Overview:
- Parametrised multicycle IEEE-754 square-root unit for the FP execute stage; successor to the Newton-style sqrt block.
- Uses digit-recurrence (restoring) on the significand, so the result is exact-rounded and has a fixed latency.
- Adds runtime rounding modes, subnormal inputs, fflags, a special-case fast path and a configurable root-bits-per-cycle count.
- Carries exe_p_mux_bus_type alongside the operation, in the same way as the other multicycle units.

Parameters:
- EXP_W, 8: exponent width. Data width W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1.
- MAN_W, 23: stored fraction width. 52 gives a double-precision unit.
- RADIX_BITS, 1: root bits resolved per ITER cycle; legal values 1 or 2. Derived ITERS = ceil((MAN_W+2)/RADIX_BITS).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- clear  in  1  synchronous pipeline flush
- en  in  1  global advance; 0 = hold all state
- p_start  in  1  start request
- a_in  in  W  operand
- rm  in  3  rounding mode
- bus_i  in  $bits(exe_p_mux_bus_type)  control bus
- busy  out  1  unit occupied
- p_result  out  1  result valid, one-cycle pulse
- result_out  out  W  result
- fflags  out  5  {NV,DZ,OF,UF,NX}
- bus_o  out  $bits(exe_p_mux_bus_type)  captured bus
- uu_rd  out  5  captured bus rd, for clear logic
- uu_reg_write  out  1  captured bus reg_write
- uu_FP_reg_write  out  1  captured bus FP_reg_write

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE; busy=0, p_result=0, result_out=0, fflags=0, bus register=0.
- clear: same effect as reset, taken at the edge. Priority: rst_n > clear > en. clear wins over a simultaneous p_start.
- en=0 freezes every register, including the ITER counter. Outputs hold their values.
- States: IDLE, NORM, ITER, ROUND, DONE.
- p_start is accepted when state is IDLE or DONE and en=1. The accepting edge captures a_in, rm and bus_i.
- On acceptance, a special operand goes directly to DONE; any other operand goes to NORM.
- Special operands (results and flags):
  - any NaN gives canonical qNaN (sign 0, exponent all ones, fraction MSB 1). NV=1 only if the NaN is signalling.
  - negative nonzero, including -inf, gives qNaN with NV=1.
  - ±0 gives ±0; +inf gives +inf; no flags set.
- NORM (1 cycle):
  - Normalise subnormals with a leading-zero count.
  - Form the unbiased exponent e. If e is odd, shift the significand left by 1.
  - Result exponent = floor(e/2)+BIAS, using arithmetic shift for negative e.
  - Load the remainder and root registers and set the counter to ITERS-1.
- ITER: resolve RADIX_BITS root bits per cycle. Leave for ROUND when the counter is 0.
  - The root has MAN_W+2 bits: hidden bit, fraction, guard.
  - sticky = (remainder != 0).
- ROUND (1 cycle), round-up condition by mode:
  - RNE (000): guard & (sticky | lsb)
  - RTZ (001): never
  - RDN (010): never
  - RUP (011): guard | sticky
  - RMM (100): guard
  - codes 101–111: treated as RNE
  - A rounding carry out of the fraction increments the exponent.
  - NX = guard | sticky. DZ, OF and UF are always 0 (sqrt cannot overflow or underflow; a subnormal input gives a normal result).
- DONE: p_result=1, busy=0; result_out, fflags and bus_o are valid.
  - Next edge goes to IDLE, or to NORM/DONE if a new p_start is accepted (back-to-back).
  - result_out and fflags hold their values until the next DONE.
- busy = 1 in NORM, ITER and ROUND; 0 otherwise.
- Latency from the accepting edge (counted as edge 1), with en held high:
  - p_result is high after edge ITERS+3 (28 for the defaults).
  - Fast path: p_result is high after edge 1.
- uu_* are taken from the captured bus register. They stay valid from acceptance until the next capture or clear.

Decomposition:
- fp_pkg (shared package):
  - rm_e encodings
  - fflag bit indices
  - canonical-qNaN constant function of EXP_W/MAN_W
  - sqrt_state_e
- Sub-module fp_sqrt_digit_step: combinational step that takes remainder and root in and gives the next remainder and root out, for RADIX_BITS bits. It is instantiated once inside ITER.
- The FSM, normalise and round logic stay in fp_sqrt_iter.

Test Plan:
- a_in=0x40800000 (4.0), rm=RNE → result 0x40000000, fflags 0, p_result after edge 28.
- a_in=0x40000000 (2.0): RNE → 0x3FB504F3, RTZ → 0x3FB504F3, RUP → 0x3FB504F4; NX=1 in all three.
- Specials, p_result after edge 1:
  - 0xBF800000 → 0x7FC00000, fflags 5'b10000
  - 0x7F800001 → 0x7FC00000, NV=1
  - 0x80000000 → 0x80000000, flags 0
  - 0x7F800000 → 0x7F800000, flags 0
- Subnormal 0x00000001, RNE → 0x1A3504F3, NX=1.
- Start 4.0, then clear at ITER cycle 10 → next edge busy=0, no p_result, uu_rd=0. Drop en for 5 cycles mid-ITER → p_result delayed exactly 5 cycles, result unchanged.
- Back-to-back: p_start held during DONE with 0x3E800000 (0.25) → 0x3F000000 after a further 28 edges. MAN_W=52 build: 4.0 → 2.0 after ITERS+3 = 57 edges.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the FP execute-stage multicycle units: rounding modes,
// fflag bit positions, sqrt FSM states, the execute bus and the canonical qNaN.
package fp_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rm_e;

    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_ITER,
        S_ROUND,
        S_DONE
    } sqrt_state_e;

    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
        logic       FP_reg_write;
        logic [7:0] tag;
    } exe_p_mux_bus_type;

    // Sign 0, exponent all ones, fraction MSB set; caller keeps the low 1+exp_w+man_w bits.
    function automatic logic [63:0] canon_qnan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) v[man_w+i] = 1'b1;
        v[man_w-1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fp_sqrt_digit_step.sv
// One ITER cycle of the restoring square root: consumes RADIX_BITS radicand bit
// pairs and appends RADIX_BITS bits to the partial root.
module fp_sqrt_digit_step #(
    parameter int RADIX_BITS = 1,
    parameter int RBITS      = 25,
    parameter int REM_W      = 27
) (
    input  logic [REM_W-1:0]        rem,
    input  logic [RBITS-1:0]        root,
    input  logic [2*RADIX_BITS-1:0] rad_bits,
    output logic [REM_W-1:0]        rem_next,
    output logic [RBITS-1:0]        root_next
);

    logic [REM_W+1:0] r;
    logic [REM_W+1:0] trial;
    logic [RBITS-1:0] q;

    always_comb begin
        r     = {2'b00, rem};
        q     = root;
        trial = '0;
        for (int i = 0; i < RADIX_BITS; i++) begin
            r     = {r[REM_W-1:0], rad_bits[2*(RADIX_BITS-1-i) +: 2]};
            trial = {2'b00, q, 2'b01};
            if (r >= trial) begin
                r = r - trial;
                q = {q[RBITS-2:0], 1'b1};
            end else begin
                q = {q[RBITS-2:0], 1'b0};
            end
        end
        rem_next  = r[REM_W-1:0];
        root_next = q;
    end

endmodule

// File: rtl/fp_sqrt_iter.sv
// Multicycle IEEE-754 square root: special-case fast path, subnormal normalise,
// digit-recurrence root extraction and runtime-mode rounding with fflags.
module fp_sqrt_iter
    import fp_pkg::*;
#(
    parameter int EXP_W      = 8,
    parameter int MAN_W      = 23,
    parameter int RADIX_BITS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     en,
    input  logic                     p_start,
    input  logic [EXP_W+MAN_W:0]     a_in,
    input  logic [2:0]               rm,
    input  exe_p_mux_bus_type        bus_i,
    output logic                     busy,
    output logic                     p_result,
    output logic [EXP_W+MAN_W:0]     result_out,
    output logic [4:0]               fflags,
    output exe_p_mux_bus_type        bus_o,
    output logic [4:0]               uu_rd,
    output logic                     uu_reg_write,
    output logic                     uu_FP_reg_write
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int BIAS  = 2**(EXP_W-1) - 1;
    localparam int ITERS = (MAN_W + 2 + RADIX_BITS - 1) / RADIX_BITS;
    localparam int RBITS = ITERS * RADIX_BITS;
    localparam int REM_W = RBITS + 2;
    localparam int RAD_W = 2 * RBITS;
    localparam int CNT_W = $clog2(ITERS + 1);
    localparam int EW    = EXP_W + 2;
    localparam int LZ_W  = $clog2(MAN_W + 1);
    localparam logic [63:0]          QNAN64 = canon_qnan(EXP_W, MAN_W);
    localparam logic [W-1:0]         QNAN   = QNAN64[W-1:0];
    localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);

    sqrt_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic [W-2:0]     a_hold;
    logic [2:0]       rm_q;
    logic [RAD_W-1:0] rad;
    logic [REM_W-1:0] rem, rem_nx;
    logic [RBITS-1:0] root, root_nx;
    logic [EXP_W-1:0] exp_q;

    function automatic logic [LZ_W-1:0] lzc(input logic [MAN_W-1:0] f);
        logic [LZ_W-1:0] n;
        n = LZ_W'(MAN_W);
        for (int i = 0; i < MAN_W; i++) if (f[i]) n = LZ_W'(MAN_W - 1 - i);
        return n;
    endfunction

    function automatic logic round_up(input logic [2:0] mode, input logic g, input logic s,
                                      input logic l);
        case (mode)
            RM_RTZ, RM_RDN: return 1'b0;
            RM_RUP:         return g | s;
            RM_RMM:         return g;
            default:        return g & (s | l);
        endcase
    endfunction

    // Operand classification on the accepting edge.
    logic               in_sign;
    logic [EXP_W-1:0]   in_exp;
    logic [MAN_W-1:0]   in_frac;
    logic               special, spec_nv;
    logic [W-1:0]       spec_res;

    assign {in_sign, in_exp, in_frac} = a_in;

    always_comb begin
        special  = 1'b1;
        spec_res = QNAN;
        spec_nv  = 1'b0;
        if (in_exp == '1 && in_frac != '0)      spec_nv  = ~in_frac[MAN_W-1];
        else if (in_exp == '0 && in_frac == '0) spec_res = a_in;
        else if (in_sign)                       spec_nv  = 1'b1;
        else if (in_exp == '1)                  spec_res = a_in;
        else                                    special  = 1'b0;
    end

    // NORM: an odd exponent moves one factor of two into the radicand.
    logic [EXP_W-1:0]       n_exp;
    logic [MAN_W-1:0]       n_frac;
    logic [LZ_W-1:0]        lz;
    logic [MAN_W:0]         sig;
    logic [MAN_W+1:0]       msh;
    logic signed [EW-1:0]   e_unb, e_half;

    assign n_exp  = a_hold[W-2 -: EXP_W];
    assign n_frac = a_hold[MAN_W-1:0];

    always_comb begin
        lz = lzc(n_frac);
        if (n_exp == '0) begin
            sig   = {1'b0, n_frac} << (lz + 1);
            e_unb = -BIAS_S - $signed(EW'(lz));
        end else begin
            sig   = {1'b1, n_frac};
            e_unb = $signed(EW'(n_exp)) - BIAS_S;
        end
        msh    = e_unb[0] ? {sig, 1'b0} : {1'b0, sig};
        e_half = (e_unb >>> 1) + BIAS_S;
    end

    fp_sqrt_digit_step #(
        .RADIX_BITS(RADIX_BITS),
        .RBITS     (RBITS),
        .REM_W     (REM_W)
    ) u_step (
        .rem      (rem),
        .root     (root),
        .rad_bits (rad[RAD_W-1 -: 2*RADIX_BITS]),
        .rem_next (rem_nx),
        .root_next(root_nx)
    );

    // ROUND: root bits below the guard (odd root count at radix 4) fold into sticky.
    logic [RBITS:0]     rp;
    logic               g_bit, l_bit, st_bit;
    logic [MAN_W:0]     sum;
    logic [EXP_W-1:0]   r_exp;
    logic [W-1:0]       round_res;

    always_comb begin
        rp        = {root, 1'b0};
        g_bit     = rp[RBITS-MAN_W-1];
        l_bit     = rp[RBITS-MAN_W];
        st_bit    = (rem != '0) | (|rp[RBITS-MAN_W-2:0]);
        sum       = {1'b0, rp[RBITS-1 -: MAN_W]} + (MAN_W+1)'(round_up(rm_q, g_bit, st_bit, l_bit));
        r_exp     = exp_q + EXP_W'(sum[MAN_W]);
        round_res = {1'b0, r_exp, sum[MAN_W-1:0]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state      <= S_IDLE;
            cnt        <= '0;
            result_out <= '0;
            fflags     <= '0;
            bus_o      <= '0;
        end else if (en) begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (p_start) begin
                        bus_o <= bus_i;
                        if (special) begin
                            state         <= S_DONE;
                            result_out    <= spec_res;
                            fflags        <= '0;
                            fflags[FF_NV] <= spec_nv;
                        end else begin
                            state <= S_NORM;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_NORM: begin
                    state <= S_ITER;
                    cnt   <= CNT_W'(ITERS - 1);
                end
                S_ITER: begin
                    if (cnt == '0) state <= S_ROUND;
                    else           cnt   <= cnt - 1'b1;
                end
                S_ROUND: begin
                    state         <= S_DONE;
                    result_out    <= round_res;
                    fflags        <= '0;
                    fflags[FF_NX] <= g_bit | st_bit;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (p_start) begin
                        a_hold <= a_in[W-2:0];
                        rm_q   <= rm;
                    end
                end
                S_NORM: begin
                    rad   <= {msh, {(RAD_W-MAN_W-2){1'b0}}};
                    rem   <= '0;
                    root  <= '0;
                    exp_q <= EXP_W'(e_half);
                end
                S_ITER: begin
                    rad  <= rad << (2*RADIX_BITS);
                    rem  <= rem_nx;
                    root <= root_nx;
                end
                default: ;
            endcase
        end
    end

    assign busy            = (state == S_NORM) || (state == S_ITER) || (state == S_ROUND);
    assign p_result        = (state == S_DONE);
    assign uu_rd           = bus_o.rd;
    assign uu_reg_write    = bus_o.reg_write;
    assign uu_FP_reg_write = bus_o.FP_reg_write;

endmodule

// File: tb/tb_fp_sqrt_iter.sv
// Scoreboard bench for fp_sqrt_iter: drivers push expected results with their
// due cycle, monitors pop and compare whenever p_result is high.
module tb_fp_sqrt_iter;
    import fp_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, clear, en, p_start, p_start64;
    logic [31:0]       a_in;
    logic [63:0]       a64;
    logic [2:0]        rm;
    exe_p_mux_bus_type bus_i;

    logic              busy, p_result, uu_reg_write, uu_FP_reg_write;
    logic [31:0]       result_out;
    logic [4:0]        fflags, uu_rd;
    exe_p_mux_bus_type bus_o;

    logic              busy64, p_result64, uu_reg_write64, uu_FP_reg_write64;
    logic [63:0]       result64;
    logic [4:0]        fflags64, uu_rd64;
    exe_p_mux_bus_type bus_o64;

    fp_sqrt_iter dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .en(en), .p_start(p_start),
        .a_in(a_in), .rm(rm), .bus_i(bus_i), .busy(busy), .p_result(p_result),
        .result_out(result_out), .fflags(fflags), .bus_o(bus_o), .uu_rd(uu_rd),
        .uu_reg_write(uu_reg_write), .uu_FP_reg_write(uu_FP_reg_write)
    );

    fp_sqrt_iter #(.EXP_W(11), .MAN_W(52), .RADIX_BITS(1)) dut64 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .en(en), .p_start(p_start64),
        .a_in(a64), .rm(rm), .bus_i(bus_i), .busy(busy64), .p_result(p_result64),
        .result_out(result64), .fflags(fflags64), .bus_o(bus_o64), .uu_rd(uu_rd64),
        .uu_reg_write(uu_reg_write64), .uu_FP_reg_write(uu_FP_reg_write64)
    );

    typedef struct {
        string       name;
        logic [63:0] res;
        logic [4:0]  flg;
        int          cyc;
        logic [14:0] bus;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    exp_t e32, e64;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_issue = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && p_result) begin
            if (q32.size() == 0) begin
                chk("unexpected_p_result", 64'(result_out), 64'h0);
            end else begin
                e32 = q32.pop_front();
                chk({e32.name, ".result"}, 64'(result_out), e32.res);
                chk({e32.name, ".fflags"}, 64'(fflags), 64'(e32.flg));
                chk({e32.name, ".cycle"}, 64'(cyc), 64'(e32.cyc));
                chk({e32.name, ".bus_o"}, 64'(bus_o), 64'(e32.bus));
                chk({e32.name, ".uu_rd"}, 64'(uu_rd), 64'(e32.bus[14:10]));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && p_result64) begin
            if (q64.size() == 0) begin
                chk("unexpected_p_result64", result64, 64'h0);
            end else begin
                e64 = q64.pop_front();
                chk({e64.name, ".result"}, result64, e64.res);
                chk({e64.name, ".fflags"}, 64'(fflags64), 64'(e64.flg));
                chk({e64.name, ".cycle"}, 64'(cyc), 64'(e64.cyc));
            end
        end
    end

    // lat = edges after the accepting edge at which p_result is due.
    task automatic issue(input string name, input logic [31:0] a, input logic [2:0] mode,
                         input logic [31:0] res, input logic [4:0] flg, input int lat,
                         input bit push, input bit sync);
        if (sync) @(negedge clk);
        n_issue++;
        a_in               = a;
        rm                 = mode;
        bus_i.rd           = 5'(n_issue + 3);
        bus_i.reg_write    = n_issue[0];
        bus_i.FP_reg_write = ~n_issue[0];
        bus_i.tag          = 8'(n_issue * 37);
        p_start            = 1'b1;
        @(posedge clk);
        #1;
        if (push) q32.push_back('{name, 64'(res), flg, cyc + lat, 15'(bus_i)});
        p_start = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (q32.size() == 0 && q64.size() == 0) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL %s: timeout, %0d results still pending", name, q32.size() + q64.size());
        q32.delete();
        q64.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; en = 1'b1; p_start = 1'b1; p_start64 = 1'b0;
        a_in = 32'h4080_0000; a64 = '0; rm = 3'b000; bus_i = '1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.busy", 64'(busy), 64'h0);
        chk("reset.p_result", 64'(p_result), 64'h0);
        chk("reset.result_out", 64'(result_out), 64'h0);
        chk("reset.fflags", 64'(fflags), 64'h0);
        chk("reset.bus_o", 64'(bus_o), 64'h0);
        chk("reset.uu_rd", 64'(uu_rd), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        p_start = 1'b0;

        issue("sqrt4", 32'h4080_0000, 3'b000, 32'h4000_0000, 5'b00000, 27, 1, 1);
        drain("sqrt4");
        @(negedge clk);
        chk("hold.result_out", 64'(result_out), 64'h4000_0000);
        chk("hold.busy", 64'(busy), 64'h0);

        issue("sqrt2_rne", 32'h4000_0000, 3'b000, 32'h3FB5_04F3, 5'b00001, 27, 1, 1);
        drain("sqrt2_rne");
        issue("sqrt2_rtz", 32'h4000_0000, 3'b001, 32'h3FB5_04F3, 5'b00001, 27, 1, 1);
        drain("sqrt2_rtz");
        issue("sqrt2_rup", 32'h4000_0000, 3'b011, 32'h3FB5_04F4, 5'b00001, 27, 1, 1);
        drain("sqrt2_rup");
        issue("sqrt2_rdn", 32'h4000_0000, 3'b010, 32'h3FB5_04F3, 5'b00001, 27, 1, 1);
        drain("sqrt2_rdn");
        issue("sqrt2_rmm", 32'h4000_0000, 3'b100, 32'h3FB5_04F3, 5'b00001, 27, 1, 1);
        drain("sqrt2_rmm");
        issue("sqrt2_rm7", 32'h4000_0000, 3'b111, 32'h3FB5_04F3, 5'b00001, 27, 1, 1);
        drain("sqrt2_rm7");

        // Specials are accepted straight out of DONE, one per cycle.
        issue("neg_one", 32'hBF80_0000, 3'b000, 32'h7FC0_0000, 5'b10000, 0, 1, 1);
        issue("snan",    32'h7F80_0001, 3'b000, 32'h7FC0_0000, 5'b10000, 0, 1, 1);
        issue("qnan",    32'hFFC0_0001, 3'b000, 32'h7FC0_0000, 5'b00000, 0, 1, 1);
        issue("neg_zero", 32'h8000_0000, 3'b000, 32'h8000_0000, 5'b00000, 0, 1, 1);
        issue("pos_inf", 32'h7F80_0000, 3'b000, 32'h7F80_0000, 5'b00000, 0, 1, 1);
        issue("neg_inf", 32'hFF80_0000, 3'b000, 32'h7FC0_0000, 5'b10000, 0, 1, 1);
        drain("specials");

        issue("subnormal", 32'h0000_0001, 3'b000, 32'h1A35_04F3, 5'b00001, 27, 1, 1);
        drain("subnormal");

        issue("clr_mid", 32'h4080_0000, 3'b000, 32'h0, 5'b0, 0, 0, 1);
        repeat (11) @(negedge clk);
        chk("clr_mid.busy_before", 64'(busy), 64'h1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_mid.busy", 64'(busy), 64'h0);
        chk("clr_mid.p_result", 64'(p_result), 64'h0);
        chk("clr_mid.uu_rd", 64'(uu_rd), 64'h0);
        clear = 1'b0;
        repeat (30) @(negedge clk);

        @(negedge clk);
        a_in = 32'h4080_0000;
        p_start = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_vs_start.busy", 64'(busy), 64'h0);
        p_start = 1'b0;
        clear = 1'b0;

        issue("en_hold", 32'h4080_0000, 3'b000, 32'h4000_0000, 5'b00000, 32, 1, 1);
        repeat (8) @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
        en = 1'b1;
        drain("en_hold");

        issue("b2b_first", 32'h4080_0000, 3'b000, 32'h4000_0000, 5'b00000, 27, 1, 1);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 60 && !seen; i++) begin
                @(negedge clk);
                if (p_result) seen = 1'b1;
            end
            if (!seen) begin
                n_tests++;
                n_fail++;
                $display("FAIL b2b_wait: p_result never seen, got 0 want 1");
            end
        end
        issue("b2b_second", 32'h3E80_0000, 3'b000, 32'h3F00_0000, 5'b00000, 27, 1, 0);
        drain("b2b_second");

        @(negedge clk);
        a64 = 64'h4010_0000_0000_0000;
        rm = 3'b000;
        p_start64 = 1'b1;
        @(posedge clk);
        #1;
        q64.push_back('{"dp_sqrt4", 64'h4000_0000_0000_0000, 5'b00000, cyc + 56, 15'h0});
        p_start64 = 1'b0;
        drain("dp_sqrt4");

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
